// File: rtl/sat_narrow.sv
// sat_narrow: narrows signed IN_W-bit values to signed OUT_W-bit words with
// saturation. Two-stage valid/ready pipeline plus saturation statistics.
module sat_narrow #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_sat,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sat_count,
  output logic             sat_sticky
);

  localparam logic [OUT_W-1:0] MAX_W = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_W = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_data_q,  s1_data_d;
  logic             s1_hi_q,    s1_hi_d;
  logic             s1_lo_q,    s1_lo_d;
  // stage 2 state (drives the output port)
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sat_q,   out_sat_d;
  // statistics
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  logic                 adv1, adv2, in_fire;
  logic [IN_W-OUT_W:0]  top_bits;
  logic                 in_hi, in_lo;
  logic [OUT_W-1:0]     sel_data;

  // The value fits iff the sign bit and everything above it are all equal;
  // otherwise the sign tells which rail it overflowed.
  always_comb begin
    top_bits = in_data[IN_W-1:OUT_W-1];
    in_hi    = ~in_data[IN_W-1] & (|top_bits);
    in_lo    =  in_data[IN_W-1] & ~(&top_bits);
  end

  // Handshake: a stage may advance when the stage after it is empty or draining.
  always_comb begin
    adv2     = ~out_valid_q | out_ready;
    adv1     = ~s1_valid_q | adv2;
    in_ready = adv1;
    in_fire  = in_valid & adv1;
  end

  // Stage 2 picks the rail value or the truncated word from stage 1 flags.
  always_comb begin
    if (s1_hi_q)      sel_data = MAX_W;
    else if (s1_lo_q) sel_data = MIN_W;
    else              sel_data = s1_data_q;
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_hi_d     = s1_hi_q;
    s1_lo_d     = s1_lo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      s1_data_d  = in_data[OUT_W-1:0];
      s1_hi_d    = in_hi;
      s1_lo_d    = in_lo;
    end
    if (adv2) begin
      out_valid_d = s1_valid_q;
      out_data_d  = sel_data;
      out_sat_d   = {s1_hi_q, s1_lo_q};
    end
  end

  // Stats: clear first, then count a saturating transfer; counter pins at all-ones.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr_stats) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (in_fire && (in_hi || in_lo)) begin
      sticky_d = 1'b1;
      if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_ONE;
    end
  end

  // State registers; reset drops any words in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_hi_q     <= 1'b0;
      s1_lo_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_hi_q     <= s1_hi_d;
      s1_lo_q     <= s1_lo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign sat_count  = cnt_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_sat_narrow.sv
// Bench for sat_narrow: queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sat_narrow;
  localparam int IN_W = 32, OUT_W = 10, CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic in_ready, out_valid, sat_sticky;
  logic [OUT_W-1:0] out_data;
  logic [1:0] out_sat;
  logic [CNT_W-1:0] sat_count;
  logic in_ready2, out_valid2, sat_sticky2;
  logic [OUT_W-1:0] out_data2;
  logic [1:0] out_sat2;
  logic [1:0] sat_count2;

  always #5 clk = ~clk;

  sat_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .clr_stats(clr_stats),
    .sat_count(sat_count), .sat_sticky(sat_sticky));

  // Narrow counter instance to reach counter saturation quickly.
  sat_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sat(out_sat2), .clr_stats(clr_stats),
    .sat_count(sat_count2), .sat_sticky(sat_sticky2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference narrowing from plain signed arithmetic: {data, sat_hi, sat_lo}.
  function automatic logic [11:0] ref_narrow(input logic [31:0] x);
    int v;
    logic [9:0] lo10;
    v = $signed(x);
    lo10 = x[9:0];
    if (v > 511)  return {10'h1FF, 2'b10};
    if (v < -512) return {10'h200, 2'b01};
    return {lo10, 2'b00};
  endfunction

  // Model state: words accepted but not yet delivered, with acceptance cycle.
  typedef struct { logic [11:0] w; int acc; } ent_t;
  ent_t q[$];
  int cyc = 0;
  int m_cnt = 0, m_cnt2 = 0;
  bit m_sticky = 0;
  logic [11:0] got_q[$];

  // Compare at negedge, then advance the model by what the next rising edge does.
  initial begin
    bit ov, ir;
    logic [11:0] r;
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_sticky", sat_sticky, 0);
        chk("rst_out_valid2", out_valid2, 0);
      end else begin
        ov = (q.size() > 0) && (q[0].acc < cyc);
        ir = (q.size() < 2) || out_ready;
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, ov);
        chk("in_ready2", in_ready2, ir);
        chk("out_valid2", out_valid2, ov);
        if (ov) begin
          chk("out_word", {out_data, out_sat}, q[0].w);
          chk("out_word2", {out_data2, out_sat2}, q[0].w);
        end
        chk("sat_count", sat_count, m_cnt);
        chk("sat_sticky", sat_sticky, m_sticky);
        chk("sat_count2", sat_count2, m_cnt2);
        chk("sat_sticky2", sat_sticky2, m_sticky);
        if (ov && out_ready) begin
          got_q.push_back({out_data, out_sat});
          void'(q.pop_front());
        end
        cyc++;
        if (clr_stats) begin m_cnt = 0; m_cnt2 = 0; m_sticky = 0; end
        if (in_valid && ir) begin
          r = ref_narrow(in_data);
          e.w = r; e.acc = cyc;
          q.push_back(e);
          if (r[1:0] != 2'b00) begin
            m_sticky = 1;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end
      end
    end
  end

  // One cycle of stimulus; drive at +1 after posedge, report acceptance.
  task automatic tick(input bit v, input logic [31:0] d, input bit ordy,
                      input bit clr, output bit acc);
    in_valid = v; in_data = d; out_ready = ordy; clr_stats = clr;
    #1;
    acc = v && in_ready;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d, input bit clr);
    bit acc = 0;
    for (int k = 0; k < 64 && !acc; k++) tick(1, d, 1, clr, acc);
    chk("accept_bound", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) tick(0, '0, 1, 0, acc);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: return 32'($signed($urandom_range(0, 2047)) - 1024);
      2: return $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
      default: return 32'($signed($urandom_range(0, 7)) + 508) ^ {32{$urandom_range(0,1) == 1}};
    endcase
  endfunction

  logic [31:0] rt_in  [7] = '{32'hFFFFFE00, 32'h1, 32'hFFFFFE62, 32'h1FF, 32'hFFFFFEAE, 32'h10, 32'hFFFFFFFF};
  logic [9:0]  rt_out [7] = '{10'h200, 10'h001, 10'h262, 10'h1FF, 10'h2AE, 10'h010, 10'h3FF};
  logic [31:0] t1_in  [4] = '{32'h000001FF, 32'h00000200, 32'hFFFFFE00, 32'hFFFFFDFF};
  logic [11:0] t1_out [4] = '{{10'h1FF, 2'b00}, {10'h1FF, 2'b10}, {10'h200, 2'b00}, {10'h200, 2'b01}};

  initial begin
    bit acc;
    int i, t, nstall;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(2);

    // Round trip of in-range values
    got_q.delete();
    for (int k = 0; k < 7; k++) push_word(rt_in[k], 0);
    idle(4);
    chk("rt_count", got_q.size(), 7);
    for (int k = 0; k < 7 && k < got_q.size(); k++) chk("rt_word", got_q[k], {rt_out[k], 2'b00});
    chk("rt_sat_count", sat_count, 0);

    // Boundary values around the rails
    got_q.delete();
    for (int k = 0; k < 4; k++) push_word(t1_in[k], 0);
    idle(4);
    chk("t1_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) chk("t1_word", got_q[k], t1_out[k]);
    chk("t1_sat_count", sat_count, 2);

    // Clear coinciding with a saturating transfer
    push_word(32'h80000000, 0);
    chk("t4_pre_count", sat_count, 3);
    tick(1, 32'h7FFFFFFF, 1, 1, acc);
    chk("t4_same_count", sat_count, 1);
    chk("t4_same_sticky", sat_sticky, 1);
    tick(0, '0, 1, 1, acc);
    chk("t4_clr_count", sat_count, 0);
    chk("t4_clr_sticky", sat_sticky, 0);

    // Narrow counter pins at its maximum
    for (int k = 0; k < 5; k++) push_word(32'h7FFFFFFF, 0);
    chk("t5_count2", sat_count2, 3);
    chk("t5_count16", sat_count, 5);
    idle(3);

    // Backpressure: sink stalls for the first 4 cycles
    got_q.delete();
    i = 0; t = 0; nstall = 0;
    while (i < 5 && t < 200) begin
      tick(1, 32'(i + 1), t >= 4, 0, acc);
      if (acc) begin
        if (t < 4) nstall++;
        i++;
      end
      t++;
    end
    chk("t3_all_sent", i, 5);
    chk("t3_accepted_in_stall", nstall, 2);
    idle(4);
    chk("t3_count", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++) chk("t3_order", got_q[k], {10'(k + 1), 2'b00});

    // Reset mid-stream with two words in flight
    tick(1, 32'h00000055, 1, 0, acc);
    tick(1, 32'h00000066, 1, 0, acc);
    in_valid = 0;
    rst = 1;
    #1;
    chk("t6_out_valid_async", out_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    got_q.delete();
    push_word(32'h00000005, 0);
    push_word(32'h7FFFFFFF, 0);
    idle(4);
    chk("t6_first_after_rst", got_q.size() > 0 ? got_q[0] : 12'hFFF, {10'h005, 2'b00});

    // Randomized traffic with random backpressure and occasional clears
    for (int k = 0; k < 3000; k++)
      tick($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, acc);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
